// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the regfile write port between CPU writeback and two buffered I/O ports
module rf_write_arbiter #(
  parameter int WIDTH   = 8,
  parameter int AWIDTH  = 4,
  parameter int MAXWAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_wa,
  input  logic [WIDTH-1:0]  cpu_wd,
  input  logic              io0_valid,
  input  logic [AWIDTH-1:0] io0_wa,
  input  logic [WIDTH-1:0]  io0_wd,
  output logic              io0_ack,
  input  logic              io1_valid,
  input  logic [AWIDTH-1:0] io1_wa,
  input  logic [WIDTH-1:0]  io1_wd,
  output logic              io1_ack,
  output logic              we3,
  output logic [AWIDTH-1:0] wa3,
  output logic [WIDTH-1:0]  wd3,
  output logic              pc_enable,
  output logic              io0_pending,
  output logic              io1_pending
);
  localparam int CNTW = $clog2(MAXWAIT + 1);
  logic [1:0] full, ack, valid, starve, g;
  logic [AWIDTH-1:0] addr [2];
  logic [WIDTH-1:0] data [2];
  logic [CNTW-1:0] wt [2];
  logic [AWIDTH-1:0] in_wa [2];
  logic [WIDTH-1:0] in_wd [2];
  logic rr, stall, io_grant, gport;
  assign valid = {io1_valid, io0_valid};
  assign in_wa[0] = io0_wa;
  assign in_wa[1] = io1_wa;
  assign in_wd[0] = io0_wd;
  assign in_wd[1] = io1_wd;
  assign io0_ack = ack[0] && !reset;
  assign io1_ack = ack[1] && !reset;
  assign io0_pending = full[0] && !reset;
  assign io1_pending = full[1] && !reset;
  // A starved entry outranks the CPU; otherwise I/O only fills idle CPU cycles
  always_comb begin
    starve[0] = full[0] && wt[0] == CNTW'(MAXWAIT);
    starve[1] = full[1] && wt[1] == CNTW'(MAXWAIT);
    stall = |starve;
    io_grant = stall || (!cpu_we && |full);
    gport = stall ? ((&starve) ? rr : starve[1]) : ((&full) ? rr : full[1]);
    g = io_grant ? (gport ? 2'b10 : 2'b01) : 2'b00;
    wa3 = io_grant ? addr[gport] : cpu_wa;
    wd3 = io_grant ? data[gport] : cpu_wd;
    we3 = !reset && (io_grant || cpu_we) && wa3 != '0;
    pc_enable = reset || !stall;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      ack <= '0;
      rr <= 1'b0;
      wt <= '{default: '0};
    end else begin
      ack <= valid & ~full;
      if (io_grant) rr <= !gport;
      for (int i = 0; i < 2; i++)
        if (valid[i] && !full[i]) begin
          full[i] <= 1'b1;
          addr[i] <= in_wa[i];
          data[i] <= in_wd[i];
          wt[i] <= '0;
        end else if (g[i]) full[i] <= 1'b0;
        else if (full[i] && wt[i] != CNTW'(MAXWAIT)) wt[i] <= wt[i] + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized scoreboard bench against a per-entry behavioural model
module tb_rf_write_arbiter;
  localparam int MAXWAIT = 4;
  logic clk = 0, reset = 1;
  logic cpu_we = 0;
  logic [3:0] cpu_wa = 0;
  logic [7:0] cpu_wd = 0;
  logic io0_valid = 0, io1_valid = 0;
  logic [3:0] io0_wa = 0, io1_wa = 0;
  logic [7:0] io0_wd = 0, io1_wd = 0;
  logic io0_ack, io1_ack, we3, pc_enable, io0_pending, io1_pending;
  logic [3:0] wa3;
  logic [7:0] wd3;

  rf_write_arbiter #(.WIDTH(8), .AWIDTH(4), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd),
    .io0_valid(io0_valid), .io0_wa(io0_wa), .io0_wd(io0_wd), .io0_ack(io0_ack),
    .io1_valid(io1_valid), .io1_wa(io1_wa), .io1_wd(io1_wd), .io1_ack(io1_ack),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_enable(pc_enable),
    .io0_pending(io0_pending), .io1_pending(io1_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we;
    bit [3:0] wa;
    bit [7:0] wd;
    bit pc;
    bit [1:0] ack;
    bit [1:0] pend;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, stalls = 0;

  // model: each buffered entry remembers how long it has been waiting
  bit m_full[2], m_ack[2];
  bit [3:0] m_addr[2];
  bit [7:0] m_data[2];
  int m_age[2];
  int m_rr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("we3", we3, e.we);
        chk("pc_enable", pc_enable, e.pc);
        chk("acks", {io1_ack, io0_ack}, e.ack);
        chk("pending", {io1_pending, io0_pending}, e.pend);
        if (e.we) begin
          chk("wa3", wa3, e.wa);
          chk("wd3", wd3, e.wd);
        end
      end
    end
  end

  task automatic cycle(input bit rst, input bit cwe, input bit [3:0] cwa, input bit [7:0] cwd,
                       input bit v0, input bit [3:0] a0, input bit [7:0] d0,
                       input bit v1, input bit [3:0] a1, input bit [7:0] d1);
    exp_t e;
    bit v[2];
    bit [3:0] a[2];
    bit [7:0] d[2];
    bit st[2];
    int g;
    @(posedge clk);
    #1;
    reset = rst; cpu_we = cwe; cpu_wa = cwa; cpu_wd = cwd;
    io0_valid = v0; io0_wa = a0; io0_wd = d0;
    io1_valid = v1; io1_wa = a1; io1_wd = d1;
    v[0] = v0; v[1] = v1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    if (rst) begin
      e = '{we: 0, wa: 0, wd: 0, pc: 1, ack: 0, pend: 0};
      q.push_back(e);
      for (int k = 0; k < 2; k++) begin
        m_full[k] = 0; m_ack[k] = 0; m_age[k] = 0;
      end
      m_rr = 0;
      return;
    end
    e.ack = {m_ack[1], m_ack[0]};
    e.pend = {m_full[1], m_full[0]};
    e.pc = 1; e.we = 0; e.wa = cwa; e.wd = cwd;
    g = -1;
    for (int k = 0; k < 2; k++) st[k] = m_full[k] && m_age[k] >= MAXWAIT;
    if (st[0] || st[1]) begin
      e.pc = 0;
      stalls++;
      g = (st[0] && st[1]) ? m_rr : (st[0] ? 0 : 1);
    end else if (cwe) e.we = 1;
    else if (m_full[0] || m_full[1]) g = (m_full[0] && m_full[1]) ? m_rr : (m_full[0] ? 0 : 1);
    if (g >= 0) begin
      e.we = 1; e.wa = m_addr[g]; e.wd = m_data[g];
    end
    if (e.wa == 0) e.we = 0;
    q.push_back(e);
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = v[k] && !m_full[k];
      if (v[k] && !m_full[k]) begin
        m_full[k] = 1; m_addr[k] = a[k]; m_data[k] = d[k]; m_age[k] = 0;
      end else if (g == k) m_full[k] = 0;
      else if (m_full[k] && m_age[k] < MAXWAIT) m_age[k]++;
    end
    if (g >= 0) m_rr = 1 - g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int s;
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 1, 3, 8'h5A, 0, 0, 0, 0, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 1, 5, 8'h11, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 1, 6, 8'h22, 1, 7, 8'h33);
    idle(3);
    cycle(0, 1, 1, 8'h01, 0, 0, 0, 1, 9, 8'hAA);
    for (int i = 0; i < 8; i++) cycle(0, 1, 2, 8'(i + 8'h40), 0, 0, 0, 0, 0, 0);
    idle(1);
    s = stalls;
    cycle(0, 0, 0, 0, 1, 0, 8'h77, 0, 0, 0);
    idle(2);
    cycle(0, 1, 4, 8'h44, 1, 6, 8'h66, 1, 7, 8'h99);
    cycle(0, 1, 4, 8'h45, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 4, 8'h46, 0, 0, 0, 0, 0, 0);
    idle(2);
    checks++;
    if (s != 1) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 1", s);
    end
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(63) == 0, $urandom_range(9) < 6, 4'($urandom), 8'($urandom),
            $urandom_range(1) == 1, 4'($urandom), 8'($urandom),
            $urandom_range(2) == 0, 4'($urandom), 8'($urandom));
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0 queued entries", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
